genius_memory_game: RTL and testbench
=====================================

Name: genius_memory_game

Overview:
- Sequence-memory game controller ("Genius"/Simon style) for a 4-button/4-LED board, clocked at 1 kHz.
- Each round the player repeats the stored sequence, then enters one new move, which is appended to an internal 16x4 RAM.
- Completing round 16 correctly wins. A wrong move or a timeout loses.
- Top-level block: control FSM, datapath (address/round counters, RAM, comparator, timers) and 7-segment debug encoders.

Parameters:
- SHOW_CYCLES, 1000: clock cycles the first move is displayed on leds after start.
- TIMEOUT_CYCLES, 3000: maximum idle cycles while waiting for any button press.

Ports:
- clock, input, 1: system clock (1 kHz nominal).
- reset, input, 1: one clock; reset is asynchronous and active-low.
- iniciar, input, 1: start/restart request, level-sampled.
- botoes, input, 4: one-hot player buttons.
- leds, output, 4: move display.
- pronto, output, 1: game finished.
- ganhou, output, 1: player won.
- perdeu, output, 1: player lost (wrong move or timeout).
- db_clock, output, 1: copy of clock.
- db_tem_jogada, output, 1: OR of botoes.
- db_igual, output, 1: registered move equals RAM[endereco].
- db_enderecoIgualRodada, output, 1: endereco == rodada.
- db_timeout, output, 1: timeout occurred (latched until restart).
- db_contagem, output, 7: 7-seg of endereco.
- db_memoria, output, 7: 7-seg of RAM[endereco].
- db_estado, output, 7: 7-seg of state code.
- db_jogadafeita, output, 7: 7-seg of registered move.
- db_rodada, output, 7: 7-seg of rodada.

Behaviour:
- 7-seg encoding:
  - active-low segments, bit order gfedcba, hex digits 0-F.
  - Input is 4 bits.
- Move detection:
  - botoes is registered each cycle.
  - A move is the rising edge of the OR of botoes; botoes is captured into jogada_reg at that edge.
  - Holding a button counts once.
- RAM:
  - 16x4, synchronous write, asynchronous read.
  - Power-up/init contents: address 0 = 0001; all others = 0000.
  - RAM is not cleared by reset. Appended moves persist until overwritten.
- Reset (async, reset=0):
  - state INICIAL; endereco=0, rodada=0, jogada_reg=0, timers=0, timeout flag=0.
  - leds=0, pronto=0, ganhou=0, perdeu=0.
- FSM states and codes (shown on db_estado):
  - INICIAL (0): idle. Goes to PREPARA when iniciar=1.
  - PREPARA (1): clear endereco, rodada, jogada_reg, timers. Next: MOSTRA.
  - MOSTRA (2): leds=RAM[0] for SHOW_CYCLES cycles, then ESPERA.
  - ESPERA (3): timeout counter runs.
    - Move detected: REGISTRA.
    - Counter reaches TIMEOUT_CYCLES: FIM_TIMEOUT.
  - REGISTRA (4): jogada_reg valid. Next: COMPARA.
  - COMPARA (5):
    - not igual: FIM_PERDEU.
    - igual and endereco<rodada: PROXIMO.
    - igual and endereco==rodada and rodada==15: FIM_GANHOU.
    - igual and endereco==rodada and rodada<15: ESPERA_NOVA.
  - PROXIMO (6): endereco+1. Next: ESPERA.
  - ESPERA_NOVA (7): same timeout rule as ESPERA. On move: ESCREVE.
  - ESCREVE (8): RAM[rodada+1] <= captured move. Next: PROX_RODADA.
  - PROX_RODADA (9): rodada+1, endereco=0, timeout counter cleared. Next: ESPERA.
  - FIM_GANHOU (A): pronto=1, ganhou=1.
  - FIM_PERDEU (E): pronto=1, perdeu=1.
  - FIM_TIMEOUT (D): pronto=1, perdeu=1, db_timeout=1.
  - All FIM states go to PREPARA when iniciar=1. Outputs clear on leaving.
- Timeout counter clears on every state entry into ESPERA/ESPERA_NOVA and on each detected move.
- Counters:
  - endereco and rodada are 4-bit and never wrap.
  - Round 16 (rodada=15) never writes; the game ends after checking its 16 moves.
- leds: RAM[0] in MOSTRA, else 0.
- iniciar is ignored outside INICIAL/FIM states.
- Button presses outside ESPERA/ESPERA_NOVA are ignored.

Test Plan:
- Reset low mid-game (rodada=5) -> immediately state 0, all flags 0, db_rodada shows 0 (0x40).
- iniciar high 10 cycles -> MOSTRA; leds=0001 for 1000 cycles; then ESPERA (db_estado=3).
- Full game:
  - Round i: replay moves 0..i, each press 10 cycles with 10-cycle gaps.
  - Rounds 0-14: append one new move after the replay.
  - After round 15 -> ganhou=1, pronto=1, perdeu=0, db_rodada shows F.
- Round 2, second move wrong -> perdeu=1, pronto=1, db_estado=E, db_timeout=0.
- No press for 3000 cycles in ESPERA -> perdeu=1, db_timeout=1, db_estado=D.
- Button held 10 cycles -> exactly one move registered (endereco advances by 1).
- In FIM_PERDEU, pulse iniciar -> new game: rodada=0, leds show RAM[0], RAM keeps previously written moves.

Source files
------------

// File: rtl/genius_memory_game_if.sv
// Player-facing signal bundle of the Genius memory game.
//   iniciar : start/restart request, level-sampled
//   botoes  : one-hot player buttons
//   leds    : move display
//   pronto  : game finished
//   ganhou  : player won
//   perdeu  : player lost (wrong move or timeout)
// master = board/player side, slave = game controller.
interface genius_memory_game_if;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;

  modport master (
    output iniciar, botoes,
    input  leds, pronto, ganhou, perdeu
  );

  modport slave (
    input  iniciar, botoes,
    output leds, pronto, ganhou, perdeu
  );
endinterface

// File: rtl/genius_memory_game.sv
// Sequence-memory game controller (Simon style) for a 4-button/4-LED board.
// Each round the player replays the stored sequence and then enters one new
// move, which is appended to a 16x4 RAM. Round 16 completed correctly wins;
// a wrong move or an idle timeout loses.
// Ports:
//   clock                  : system clock (1 kHz nominal)
//   reset                  : asynchronous, active-low
//   game                   : player interface (iniciar, botoes, leds, pronto, ganhou, perdeu)
//   db_clock               : copy of clock
//   db_tem_jogada          : OR of the raw buttons
//   db_igual               : registered move equals RAM[endereco]
//   db_enderecoIgualRodada : endereco == rodada
//   db_timeout             : timeout occurred, held until restart
//   db_contagem/db_memoria/db_estado/db_jogadafeita/db_rodada :
//                            7-segment (active-low, gfedcba) debug digits
module genius_memory_game #(
  parameter int SHOW_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic                       clock,
  input  logic                       reset,
  genius_memory_game_if.slave        game,
  output logic                       db_clock,
  output logic                       db_tem_jogada,
  output logic                       db_igual,
  output logic                       db_enderecoIgualRodada,
  output logic                       db_timeout,
  output logic [6:0]                 db_contagem,
  output logic [6:0]                 db_memoria,
  output logic [6:0]                 db_estado,
  output logic [6:0]                 db_jogadafeita,
  output logic [6:0]                 db_rodada
);

  localparam logic [3:0] S_INICIAL     = 4'h0;
  localparam logic [3:0] S_PREPARA     = 4'h1;
  localparam logic [3:0] S_MOSTRA      = 4'h2;
  localparam logic [3:0] S_ESPERA      = 4'h3;
  localparam logic [3:0] S_REGISTRA    = 4'h4;
  localparam logic [3:0] S_COMPARA     = 4'h5;
  localparam logic [3:0] S_PROXIMO     = 4'h6;
  localparam logic [3:0] S_ESPERA_NOVA = 4'h7;
  localparam logic [3:0] S_ESCREVE     = 4'h8;
  localparam logic [3:0] S_PROX_RODADA = 4'h9;
  localparam logic [3:0] S_FIM_GANHOU  = 4'hA;
  localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] S_FIM_PERDEU  = 4'hE;

  // One timer serves both the display phase and the idle timeout, so it is
  // sized for the longer of the two.
  localparam int MAX_CYCLES = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [3:0]       state;
  logic [3:0]       endereco;
  logic [3:0]       rodada;
  logic [3:0]       jogada_reg;
  logic [TMR_W-1:0] tmr;
  logic             timeout_flag;
  logic [3:0]       botoes_p0;
  logic             tem_p1;

  // Move RAM keeps its contents across reset; only address 0 is preloaded.
  logic [3:0] mem [16] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                           4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  logic [3:0] mem_rd;
  logic       igual;
  logic       end_eq;
  logic       jogada;

  assign mem_rd = mem[endereco];
  assign igual  = (jogada_reg == mem_rd);
  assign end_eq = (endereco == rodada);
  // Rising edge of the registered button OR: a held button counts once.
  assign jogada = (|botoes_p0) & ~tem_p1;

  // Stage p0: buttons registered; stage p1: previous OR for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_INICIAL;
      endereco     <= 4'd0;
      rodada       <= 4'd0;
      jogada_reg   <= 4'd0;
      tmr          <= '0;
      timeout_flag <= 1'b0;
      botoes_p0    <= 4'd0;
      tem_p1       <= 1'b0;
    end else begin
      botoes_p0 <= game.botoes;
      tem_p1    <= |botoes_p0;
      case (state)
        S_INICIAL: if (game.iniciar) state <= S_PREPARA;
        S_PREPARA: begin
          endereco     <= 4'd0;
          rodada       <= 4'd0;
          jogada_reg   <= 4'd0;
          tmr          <= '0;
          timeout_flag <= 1'b0;
          state        <= S_MOSTRA;
        end
        S_MOSTRA: begin
          if (tmr == SHOW_LAST) begin
            tmr   <= '0;
            state <= S_ESPERA;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_ESPERA, S_ESPERA_NOVA: begin
          if (jogada) begin
            jogada_reg <= botoes_p0;
            tmr        <= '0;
            state      <= (state == S_ESPERA) ? S_REGISTRA : S_ESCREVE;
          end else if (tmr == TMO_LAST) begin
            timeout_flag <= 1'b1;
            state        <= S_FIM_TIMEOUT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_REGISTRA: state <= S_COMPARA;
        S_COMPARA: begin
          tmr <= '0;
          // endereco never exceeds rodada, so "not equal" means endereco < rodada
          if (!igual)               state <= S_FIM_PERDEU;
          else if (!end_eq)         state <= S_PROXIMO;
          else if (rodada == 4'd15) state <= S_FIM_GANHOU;
          else                      state <= S_ESPERA_NOVA;
        end
        S_PROXIMO: begin
          endereco <= endereco + 4'd1;
          tmr      <= '0;
          state    <= S_ESPERA;
        end
        S_ESCREVE: state <= S_PROX_RODADA;
        S_PROX_RODADA: begin
          rodada   <= rodada + 4'd1;
          endereco <= 4'd0;
          tmr      <= '0;
          state    <= S_ESPERA;
        end
        S_FIM_GANHOU, S_FIM_PERDEU, S_FIM_TIMEOUT: begin
          if (game.iniciar) begin
            timeout_flag <= 1'b0;
            state        <= S_PREPARA;
          end
        end
        default: state <= S_INICIAL;
      endcase
    end
  end

  // The final round never writes, so rodada+1 stays within the RAM.
  always_ff @(posedge clock) begin
    if (state == S_ESCREVE) mem[rodada + 4'd1] <= jogada_reg;
  end

  assign game.leds   = (state == S_MOSTRA) ? mem[0] : 4'd0;
  assign game.pronto = (state == S_FIM_GANHOU) || (state == S_FIM_PERDEU) ||
                       (state == S_FIM_TIMEOUT);
  assign game.ganhou = (state == S_FIM_GANHOU);
  assign game.perdeu = (state == S_FIM_PERDEU) || (state == S_FIM_TIMEOUT);

  assign db_clock               = clock;
  assign db_tem_jogada          = |game.botoes;
  assign db_igual               = igual;
  assign db_enderecoIgualRodada = end_eq;
  assign db_timeout             = timeout_flag;
  assign db_contagem            = hex7(endereco);
  assign db_memoria             = hex7(mem_rd);
  assign db_estado              = hex7(state);
  assign db_jogadafeita         = hex7(jogada_reg);
  assign db_rodada              = hex7(rodada);

endmodule

// File: tb/tb_genius_memory_game.sv
// Directed testbench for genius_memory_game: reset, display phase, a full
// winning game, mid-game reset, wrong move, restart and idle timeout.
module tb_genius_memory_game;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  genius_memory_game_if gif();

  logic       db_clock, db_tem_jogada, db_igual, db_enderecoIgualRodada, db_timeout;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;

  genius_memory_game dut (
    .clock                  (clock),
    .reset                  (reset),
    .game                   (gif),
    .db_clock               (db_clock),
    .db_tem_jogada          (db_tem_jogada),
    .db_igual               (db_igual),
    .db_enderecoIgualRodada (db_enderecoIgualRodada),
    .db_timeout             (db_timeout),
    .db_contagem            (db_contagem),
    .db_memoria             (db_memoria),
    .db_estado              (db_estado),
    .db_jogadafeita         (db_jogadafeita),
    .db_rodada              (db_rodada)
  );

  // Move to play at sequence position k, and the 7-segment code of digit k.
  typedef struct {
    logic [3:0] move;
    logic [6:0] seg;
  } vec_t;

  vec_t tbl [16];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   lc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] btn);
    gif.botoes = btn;
    cycles(10);
    gif.botoes = 4'd0;
    cycles(10);
  endtask

  task automatic wait_estado(input string name, input logic [6:0] seg, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (db_estado == seg) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // Raise iniciar for 'hold' cycles, count display cycles with leds=0001 until ESPERA.
  task automatic start_game(input int hold, output int ledcnt);
    bit ok;
    ok     = 1'b0;
    ledcnt = 0;
    gif.iniciar = 1'b1;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clock);
      if (i == hold - 1) gif.iniciar = 1'b0;
      if (gif.leds == 4'b0001) ledcnt++;
      if (db_estado == 7'h30) begin
        ok = 1'b1;
        break;
      end
    end
    gif.iniciar = 1'b0;
    check("reach_espera", ok, 1);
  endtask

  // Replay positions 0..r and append position r+1.
  task automatic play_round(input int r);
    for (int k = 0; k <= r; k++) press(tbl[k].move);
    press(tbl[r + 1].move);
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 7'h40};  tbl[1]  = '{4'b0010, 7'h79};
    tbl[2]  = '{4'b0100, 7'h24};  tbl[3]  = '{4'b1000, 7'h30};
    tbl[4]  = '{4'b0100, 7'h19};  tbl[5]  = '{4'b0001, 7'h12};
    tbl[6]  = '{4'b1000, 7'h02};  tbl[7]  = '{4'b0010, 7'h78};
    tbl[8]  = '{4'b0010, 7'h00};  tbl[9]  = '{4'b0100, 7'h10};
    tbl[10] = '{4'b0001, 7'h08};  tbl[11] = '{4'b1000, 7'h03};
    tbl[12] = '{4'b1000, 7'h46};  tbl[13] = '{4'b0010, 7'h21};
    tbl[14] = '{4'b0100, 7'h06};  tbl[15] = '{4'b0001, 7'h0E};

    gif.iniciar = 1'b0;
    gif.botoes  = 4'd0;
    reset       = 1'b0;
    cycles(3);
    check("rst_estado", db_estado, 7'h40);
    check("rst_pronto", gif.pronto, 0);
    check("rst_ganhou", gif.ganhou, 0);
    check("rst_perdeu", gif.perdeu, 0);
    check("rst_leds", gif.leds, 0);
    check("rst_contagem", db_contagem, 7'h40);
    check("rst_timeout", db_timeout, 0);
    reset = 1'b1;
    cycles(3);
    check("idle_estado", db_estado, 7'h40);

    // Display phase: leds show RAM[0] for exactly 1000 cycles
    start_game(10, lc);
    check("mostra_led_cycles", lc, 1000);

    // Full winning game
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k <= r; k++) begin
        press(tbl[k].move);
        if (r == 2 && k == 0) check("held_once_endereco", db_contagem, 7'h79);
      end
      if (r < 15) begin
        check("espera_nova_estado", db_estado, 7'h78);
        check("igual", db_igual, 1);
        check("end_eq_rodada", db_enderecoIgualRodada, 1);
        press(tbl[r + 1].move);
        check("rodada_seg", db_rodada, tbl[r + 1].seg);
        check("after_append_estado", db_estado, 7'h30);
      end
    end
    check("win_ganhou", gif.ganhou, 1);
    check("win_pronto", gif.pronto, 1);
    check("win_perdeu", gif.perdeu, 0);
    check("win_rodada", db_rodada, 7'h0E);
    check("win_estado", db_estado, 7'h08);

    // Asynchronous reset in the middle of round 5
    start_game(1, lc);
    for (int r = 0; r < 5; r++) play_round(r);
    check("mid_rodada5", db_rodada, 7'h12);
    reset = 1'b0;
    #1;
    check("async_rst_estado", db_estado, 7'h40);
    check("async_rst_rodada", db_rodada, 7'h40);
    check("async_rst_flags", {gif.pronto, gif.ganhou, gif.perdeu}, 3'b000);
    cycles(2);
    reset = 1'b1;
    cycles(2);

    // Wrong second move in round 2; RAM[0] must have survived reset
    start_game(1, lc);
    check("ram0_kept_leds", lc, 1000);
    play_round(0);
    play_round(1);
    press(tbl[0].move);
    press(4'b1000);
    check("wrong_perdeu", gif.perdeu, 1);
    check("wrong_pronto", gif.pronto, 1);
    check("wrong_ganhou", gif.ganhou, 0);
    check("wrong_estado", db_estado, 7'h06);
    check("wrong_timeout", db_timeout, 0);

    // Restart from FIM_PERDEU with a one-cycle iniciar pulse
    gif.iniciar = 1'b1;
    cycles(1);
    gif.iniciar = 1'b0;
    cycles(5);
    check("restart_estado", db_estado, 7'h24);
    check("restart_leds", gif.leds, 4'b0001);
    check("restart_rodada", db_rodada, 7'h40);
    check("restart_memoria", db_memoria, 7'h79);
    check("restart_perdeu", gif.perdeu, 0);
    wait_estado("restart_espera", 7'h30, 1100);

    // Idle timeout
    cycles(2990);
    check("pre_timeout_estado", db_estado, 7'h30);
    check("pre_timeout_perdeu", gif.perdeu, 0);
    cycles(20);
    check("timeout_perdeu", gif.perdeu, 1);
    check("timeout_pronto", gif.pronto, 1);
    check("timeout_flag", db_timeout, 1);
    check("timeout_estado", db_estado, 7'h21);

    // Buttons are ignored in an end state
    gif.botoes = 4'b0100;
    cycles(3);
    check("tem_jogada", db_tem_jogada, 1);
    check("fim_ignores_press", db_estado, 7'h21);
    gif.botoes = 4'd0;
    cycles(3);
    gif.iniciar = 1'b1;
    cycles(1);
    gif.iniciar = 1'b0;
    cycles(2);
    check("timeout_cleared", db_timeout, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
